// File: rtl/drop_scheduler.sv
// Gravity scheduler: counts timer ticks and raises one-row drop requests over req/ack.
// Optional feature macro DROP_SCHED_SOFT_DROP_EN: when defined, soft_drop collapses the interval to one tick.
module drop_scheduler #(
  parameter int BASE_TICKS = 10,
  parameter int MIN_TICKS  = 1,
  parameter int LEVEL_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        tick_count,
  output logic               timer_clr,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               pause,
  input  logic               piece_spawn,
  output logic               drop_req,
  input  logic               drop_ack,
  output logic               overrun
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_REQ = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] prev_tick_q, prev_tick_d;
  logic [7:0]  elapsed_q, elapsed_d;
  logic        drop_req_q, drop_req_d;
  logic        timer_clr_q, timer_clr_d;
  logic        overrun_q, overrun_d;

  logic        tick_s;
  logic        count_s;
  int          level_diff_s;
  logic [9:0]  level_interval_s;
  logic [9:0]  interval_s;
  logic        due_s;
  logic        late_s;

  // Only a +1 step of the timer is a tick; any other change (timer clear, jump) just resyncs.
  assign tick_s      = (tick_count == (prev_tick_q + 32'd1));
  assign count_s     = tick_s && !pause;
  assign prev_tick_d = tick_count;

  // Level-derived interval, computed signed so levels beyond BASE_TICKS clamp to the floor.
  always_comb begin
    level_diff_s = BASE_TICKS - int'({1'b0, level});
    if (level_diff_s > MIN_TICKS) begin
      level_interval_s = 10'(level_diff_s);
    end else begin
      level_interval_s = 10'(MIN_TICKS);
    end
  end

`ifdef DROP_SCHED_SOFT_DROP_EN
  assign interval_s = soft_drop ? 10'd1 : level_interval_s;
`else
  logic soft_drop_unused_s;
  assign soft_drop_unused_s = soft_drop;
  assign interval_s         = level_interval_s;
`endif

  assign due_s  = ({2'b00, elapsed_q} >= interval_s);
  assign late_s = ({3'b000, elapsed_q} >= {interval_s, 1'b0});

  // Next-state, elapsed counter and flag updates; piece_spawn overrides everything.
  always_comb begin
    state_d     = state_q;
    overrun_d   = overrun_q;
    timer_clr_d = 1'b0;
    if (count_s && (elapsed_q != 8'hFF)) begin
      elapsed_d = elapsed_q + 8'd1;
    end else begin
      elapsed_d = elapsed_q;
    end

    if (piece_spawn) begin
      state_d     = ST_RUN;
      elapsed_d   = 8'd0;
      overrun_d   = 1'b0;
      timer_clr_d = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!pause && due_s) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_REQ: begin
          if (late_s) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
          if (drop_ack) begin
            state_d   = ST_RUN;
            elapsed_d = 8'd0;
          end else begin
            state_d = ST_REQ;
          end
        end
        default: begin
          state_d   = ST_RUN;
          elapsed_d = 8'd0;
        end
      endcase
    end

    drop_req_d = (state_d == ST_REQ);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      prev_tick_q <= 32'd0;
      elapsed_q   <= 8'd0;
      drop_req_q  <= 1'b0;
      timer_clr_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_tick_q <= prev_tick_d;
      elapsed_q   <= elapsed_d;
      drop_req_q  <= drop_req_d;
      timer_clr_q <= timer_clr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign drop_req  = drop_req_q;
  assign timer_clr = timer_clr_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler with hand-computed expectations (default parameters).
module tb_drop_scheduler;

  logic        clk;
  logic        rst;
  logic [31:0] tick_count;
  logic        timer_clr;
  logic [3:0]  level;
  logic        soft_drop;
  logic        pause;
  logic        piece_spawn;
  logic        drop_req;
  logic        drop_ack;
  logic        overrun;

  int errs;
  int checks;

  drop_scheduler #(
    .BASE_TICKS(10),
    .MIN_TICKS (1),
    .LEVEL_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_count (tick_count),
    .timer_clr  (timer_clr),
    .level      (level),
    .soft_drop  (soft_drop),
    .pause      (pause),
    .piece_spawn(piece_spawn),
    .drop_req   (drop_req),
    .drop_ack   (drop_ack),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // n single-step increments, one per cycle, then one settle cycle for drop_req.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_count = tick_count + 32'd1;
      cyc();
    end
    cyc();
  endtask

  task automatic ack();
    drop_ack = 1'b1;
    cyc();
    drop_ack = 1'b0;
  endtask

  initial begin
    errs        = 0;
    checks      = 0;
    rst         = 1'b0;
    tick_count  = 32'd0;
    level       = 4'd0;
    soft_drop   = 1'b0;
    pause       = 1'b0;
    piece_spawn = 1'b0;
    drop_ack    = 1'b0;
    cyc();
    cyc();
    check_eq("rst_req", {31'd0, drop_req}, 32'd0);
    check_eq("rst_clr", {31'd0, timer_clr}, 32'd0);
    check_eq("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    cyc();

    // Level 0: ten increments needed, request one cycle after the tenth.
    tick_n(9);
    check_eq("l0_nine", {31'd0, drop_req}, 32'd0);
    tick_count = tick_count + 32'd1;
    cyc();
    check_eq("l0_same_cyc", {31'd0, drop_req}, 32'd0);
    cyc();
    check_eq("l0_req", {31'd0, drop_req}, 32'd1);
    ack();
    check_eq("l0_ack_fall", {31'd0, drop_req}, 32'd0);
    tick_n(9);
    check_eq("l0_reint_nine", {31'd0, drop_req}, 32'd0);
    tick_n(1);
    check_eq("l0_reint_req", {31'd0, drop_req}, 32'd1);
    ack();

    // Level 12 clamps to one tick.
    level = 4'd12;
    cyc();
    check_eq("l12_idle", {31'd0, drop_req}, 32'd0);
    tick_n(1);
    check_eq("l12_req_a", {31'd0, drop_req}, 32'd1);
    ack();
    check_eq("l12_ack", {31'd0, drop_req}, 32'd0);
    tick_n(1);
    check_eq("l12_req_b", {31'd0, drop_req}, 32'd1);
    ack();

    // Soft drop at level 0.
    level     = 4'd0;
    soft_drop = 1'b1;
`ifdef DROP_SCHED_SOFT_DROP_EN
    tick_n(1);
    check_eq("soft_req", {31'd0, drop_req}, 32'd1);
`else
    tick_n(1);
    check_eq("soft_ignored", {31'd0, drop_req}, 32'd0);
    tick_n(9);
    check_eq("soft_ign_req", {31'd0, drop_req}, 32'd1);
`endif
    ack();
    soft_drop = 1'b0;

    // Level change mid-interval: elapsed 6 already meets interval 5.
    tick_n(6);
    check_eq("lvl_pre", {31'd0, drop_req}, 32'd0);
    level = 4'd5;
    cyc();
    check_eq("lvl_change", {31'd0, drop_req}, 32'd1);
    ack();
    level = 4'd0;

    // Overrun: 20 ticks without an ack at interval 10.
    tick_n(19);
    check_eq("ovr_req", {31'd0, drop_req}, 32'd1);
    check_eq("ovr_before", {31'd0, overrun}, 32'd0);
    tick_n(1);
    check_eq("ovr_set", {31'd0, overrun}, 32'd1);
    piece_spawn = 1'b1;
    cyc();
    piece_spawn = 1'b0;
    check_eq("spawn_clr", {31'd0, timer_clr}, 32'd1);
    check_eq("spawn_req", {31'd0, drop_req}, 32'd0);
    check_eq("spawn_ovr", {31'd0, overrun}, 32'd0);
    tick_count = 32'd0;
    cyc();
    check_eq("spawn_clr_once", {31'd0, timer_clr}, 32'd0);
    tick_n(9);
    check_eq("spawn_nine", {31'd0, drop_req}, 32'd0);
    tick_n(1);
    check_eq("spawn_req10", {31'd0, drop_req}, 32'd1);
    ack();

    // Spawn coinciding with ack wins.
    level = 4'd12;
    tick_n(1);
    check_eq("sa_req", {31'd0, drop_req}, 32'd1);
    piece_spawn = 1'b1;
    drop_ack    = 1'b1;
    cyc();
    piece_spawn = 1'b0;
    drop_ack    = 1'b0;
    check_eq("sa_req_low", {31'd0, drop_req}, 32'd0);
    check_eq("sa_clr", {31'd0, timer_clr}, 32'd1);
    level = 4'd0;
    cyc();

    // Jump 57 -> 0 is a resync, then 1 counts.
    tick_n(5);
    tick_count = 32'd57;
    cyc();
    tick_count = 32'd0;
    cyc();
    tick_n(4);
    check_eq("jump_no_cnt", {31'd0, drop_req}, 32'd0);
    tick_n(1);
    check_eq("jump_req", {31'd0, drop_req}, 32'd1);
    ack();

    // Pause freezes gravity in RUN, never withdraws a pending request.
    pause = 1'b1;
    tick_n(15);
    check_eq("pause_run", {31'd0, drop_req}, 32'd0);
    pause = 1'b0;
    tick_n(9);
    check_eq("pause_frozen", {31'd0, drop_req}, 32'd0);
    tick_n(1);
    check_eq("pause_resume", {31'd0, drop_req}, 32'd1);
    pause = 1'b1;
    tick_n(3);
    check_eq("pause_req_hold", {31'd0, drop_req}, 32'd1);
    ack();
    check_eq("pause_ack", {31'd0, drop_req}, 32'd0);
    pause = 1'b0;

    // Asynchronous reset mid-request with overrun set.
    tick_n(20);
    check_eq("ar_req", {31'd0, drop_req}, 32'd1);
    check_eq("ar_ovr", {31'd0, overrun}, 32'd1);
    rst = 1'b0;
    #2;
    check_eq("ar_req_low", {31'd0, drop_req}, 32'd0);
    check_eq("ar_ovr_low", {31'd0, overrun}, 32'd0);
    check_eq("ar_clr_low", {31'd0, timer_clr}, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    tick_n(9);
    check_eq("ar_nine", {31'd0, drop_req}, 32'd0);
    tick_n(1);
    check_eq("ar_req10", {31'd0, drop_req}, 32'd1);
    ack();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
